aes_inv_cipher_iter: RTL and testbench
======================================

Name: aes_inv_cipher_iter

Overview:
Iterative AES-128 inverse cipher core that runs one decryption round per clock. It takes a ciphertext block plus the round-10 key, and derives each earlier round key on the fly by running the key expansion backwards. Each round applies InvShiftRows, then inverse SubBytes via the existing 16-byte inverse S-box stage, then AddRoundKey, then InvMixColumns. It sits between the key/ciphertext input registers and the plaintext output interface, with valid/ready on both sides.

Parameters:
None. The block is fixed to AES-128: 128-bit state, 10 rounds.

Ports:
clk  in  1  clock; all state changes on the rising edge
rst_n  in  1  synchronous, active-low reset
in_valid  in  1  ciphertext and last_key are valid
in_ready  out  1  block can accept a job; high only in IDLE
ciphertext  in  128  input block
last_key  in  128  round-10 key (final round key of the forward key schedule)
out_valid  out  1  plaintext is valid
out_ready  in  1  downstream accepts plaintext
plaintext  out  128  decrypted block
busy  out  1  high in ROUND or DONE

Behaviour:
- Byte order: state byte 0 = bits[127:120], column-major as in FIPS-197. Key word w0 = bits[127:96].
- Reset: rst_n low at a clock edge forces the following, from any state including mid-ROUND:
  - state = IDLE, rnd = 0, state register = 0, key register = 0
  - out_valid = 0, plaintext = 0, busy = 0, in_ready = 1 (takes effect from the first cycle after reset)
  - any in-flight job is discarded silently.
- FSM states: IDLE, ROUND, DONE.
- IDLE, on in_valid && in_ready:
  - st <= ciphertext ^ last_key; key <= last_key; rnd <= 9; go to ROUND.
  - ciphertext and last_key are sampled only on that edge.
- ROUND, every cycle:
  - key_prev = inv_key_step(key, RCON[rnd+1]).
  - t = InvSubBytes(InvShiftRows(st)) ^ key_prev.
  - If rnd != 0: st <= InvMixColumns(t); key <= key_prev; rnd <= rnd-1.
  - If rnd == 0: plaintext <= t; out_valid <= 1; go to DONE.
- inv_key_step, with input words w0..w3:
  - v3 = w3^w2, v2 = w2^w1, v1 = w1^w0
  - v0 = w0 ^ SubWord(RotWord(v3)) ^ {RCON,24'h0}
  - RCON[1..10] = 01,02,04,08,10,20,40,80,1b,36.
- DONE:
  - plaintext and out_valid are held stable until out_ready.
  - On out_ready: out_valid <= 0 and go to IDLE. plaintext keeps its value until the next job completes.
- Latency and throughput:
  - acceptance edge E0; rounds complete on E1..E10; out_valid is high from E10.
  - Minimum job interval is 12 cycles (acceptance blocked while in ROUND or DONE).
- Simultaneous events:
  - in_valid asserted during ROUND or DONE is ignored; the source must hold it until in_ready.
  - out_ready asserted while not in DONE has no effect.
- Widths: rnd is 4 bits and never leaves 0..9. Every arithmetic path is GF(2^8)/XOR only; there are no carries.

Decomposition:
- Shared package aes_pkg holds:
  - RCON table
  - FSM state typedef
  - xtime and GF multiply helpers (x9, xb, xd, xe)
  - byte-index helpers for InvShiftRows.
- Reuse the team's existing inverse SubBytes stage and forward S-box module; the forward S-box serves SubWord, 4 instances.
- One new combinational sub-module is natural: inv_mix_columns, a 128-bit input to 128-bit output transform.
- InvShiftRows and inv_key_step stay inline, as wiring plus XOR.

Test Plan:
1. FIPS-197 C.1: ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a, last_key 13111d7fe3944a17f307a78b4d2b30c5 -> plaintext 00112233445566778899aabbccddeeff, out_valid rising exactly 10 cycles after acceptance.
2. FIPS-197 App B: ciphertext 3925841d02dc09fbdc118597196a0b32, last_key d014f9a8c9ee2589e13f0cc8b6630ca6 -> plaintext 3243f6a8885a308d313198a2e0370734.
3. Backpressure: hold out_ready=0 for 20 cycles after out_valid -> plaintext and out_valid stable and in_ready=0 throughout; release -> IDLE next cycle, then the second vector is accepted and correct.
4. Reset mid-operation: assert rst_n=0 at round 5 for one edge -> out_valid=0, plaintext=0, busy=0, in_ready=1 next cycle; a fresh job then decrypts correctly.
5. Input ignored while busy: change ciphertext/last_key and pulse in_valid during ROUND -> first job's result is unaffected and no second job is started.
6. Back-to-back with out_ready tied 1: two jobs -> acceptance edges 12 cycles apart, both results match reference model.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: round constants, FSM encoding, GF(2^8) arithmetic,
// S-box functions and byte-index helpers used by the iterative inverse cipher.
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Entry 0 is unused so that RCON[i] is the constant of forward round i.
  localparam logic [7:0] RCON [0:10] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08,
                                         8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  function automatic logic [7:0] x9(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ b;
  endfunction

  function automatic logic [7:0] xb(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
  endfunction

  function automatic logic [7:0] xd(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
  endfunction

  function automatic logic [7:0] xe(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
  endfunction

  // b^254 is the multiplicative inverse in GF(2^8); 0 maps to 0 as AES requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] b);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = b;
    acc = 8'h01;
    for (int i = 0; i < 7; i++) begin
      sq  = gmul(sq, sq);
      acc = gmul(acc, sq);
    end
    return acc;
  endfunction

  function automatic logic [7:0] sbox_fwd(input logic [7:0] b);
    logic [7:0] v;
    v = gf_inv(b);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] sbox_inv(input logic [7:0] b);
    logic [7:0] y;
    y = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
    return gf_inv(y);
  endfunction

  // Source byte for InvShiftRows: row r of column c comes from column (c - r) mod 4.
  function automatic logic [3:0] isr_src(input logic [3:0] idx);
    logic [1:0] r;
    logic [1:0] c;
    r = idx[1:0];
    c = idx[3:2];
    return {c - r, r};
  endfunction

endpackage

// File: rtl/aes_inv_mix_columns.sv
// InvMixColumns: each column multiplied by the circulant {0e,0b,0d,09} over GF(2^8).
module aes_inv_mix_columns
  import aes_pkg::*;
(
  input  logic [127:0] d,
  output logic [127:0] q
);

  always_comb begin
    q = '0;
    for (int c = 0; c < 4; c++) begin
      logic [7:0] s0, s1, s2, s3;
      s0 = d[8*(15-4*c) +: 8];
      s1 = d[8*(14-4*c) +: 8];
      s2 = d[8*(13-4*c) +: 8];
      s3 = d[8*(12-4*c) +: 8];
      q[8*(15-4*c) +: 8] = xe(s0) ^ xb(s1) ^ xd(s2) ^ x9(s3);
      q[8*(14-4*c) +: 8] = x9(s0) ^ xe(s1) ^ xb(s2) ^ xd(s3);
      q[8*(13-4*c) +: 8] = xd(s0) ^ x9(s1) ^ xe(s2) ^ xb(s3);
      q[8*(12-4*c) +: 8] = xb(s0) ^ xd(s1) ^ x9(s2) ^ xe(s3);
    end
  end

endmodule

// File: rtl/aes_inv_sub_bytes.sv
// Inverse SubBytes over the full 16-byte state.
module aes_inv_sub_bytes
  import aes_pkg::*;
(
  input  logic [127:0] d,
  output logic [127:0] q
);

  for (genvar i = 0; i < 16; i++) begin : g_byte
    assign q[8*i +: 8] = sbox_inv(d[8*i +: 8]);
  end

endmodule

// File: rtl/aes_sbox.sv
// Forward AES S-box, one byte; used four times for SubWord in the reverse key schedule.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] a,
  output logic [7:0] y
);

  assign y = sbox_fwd(a);

endmodule

// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES-128 inverse cipher: one round per clock, round keys derived
// backwards from the round-10 key.
//
// state | meaning
// IDLE  | waiting for a job, in_ready high
// ROUND | one decryption round per cycle, rnd counts 9 down to 0
// DONE  | plaintext valid, held until out_ready
module aes_inv_cipher_iter
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] ciphertext,
  input  logic [127:0] last_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] plaintext,
  output logic         busy
);

  state_t       state, state_nxt;
  logic [127:0] st, key;
  logic [3:0]   rnd;
  logic         load, adv, fin, clr_out;

  logic [127:0] isr, isb, key_prev, t, imc;
  logic [31:0]  w0, w1, w2, w3, v0, v1, v2, v3, rotv, subw;
  logic [3:0]   rcon_idx;

  always_comb begin
    isr = '0;
    for (int i = 0; i < 16; i++)
      isr[8*(15-i) +: 8] = st[8*(15-int'(isr_src(4'(i)))) +: 8];
  end

  aes_inv_sub_bytes u_isb (.d(isr), .q(isb));

  // Reverse key schedule step: recover round key r-1 from round key r.
  assign {w0, w1, w2, w3} = key;
  assign v3       = w3 ^ w2;
  assign v2       = w2 ^ w1;
  assign v1       = w1 ^ w0;
  assign rotv     = {v3[23:0], v3[31:24]};
  assign rcon_idx = rnd + 4'd1;

  for (genvar j = 0; j < 4; j++) begin : g_subword
    aes_sbox u_sbox (.a(rotv[8*j +: 8]), .y(subw[8*j +: 8]));
  end

  assign v0       = w0 ^ subw ^ {RCON[rcon_idx], 24'h0};
  assign key_prev = {v0, v1, v2, v3};
  assign t        = isb ^ key_prev;

  aes_inv_mix_columns u_imc (.d(t), .q(imc));

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    adv       = 1'b0;
    fin       = 1'b0;
    clr_out   = 1'b0;
    in_ready  = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load      = 1'b1;
          state_nxt = ROUND;
        end
      end
      ROUND: begin
        busy = 1'b1;
        if (rnd == 4'd0) begin
          fin       = 1'b1;
          state_nxt = DONE;
        end else begin
          adv = 1'b1;
        end
      end
      DONE: begin
        busy = 1'b1;
        if (out_ready) begin
          clr_out   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st        <= '0;
      key       <= '0;
      rnd       <= 4'd0;
      plaintext <= '0;
      out_valid <= 1'b0;
    end else begin
      if (load) begin
        st  <= ciphertext ^ last_key;
        key <= last_key;
        rnd <= 4'd9;
      end
      if (adv) begin
        st  <= imc;
        key <= key_prev;
        rnd <= rnd - 4'd1;
      end
      if (fin) begin
        plaintext <= t;
        out_valid <= 1'b1;
      end
      if (clr_out) out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Self-checking bench for aes_inv_cipher_iter using FIPS-197 known-answer vectors
// and a queue of expected plaintexts pushed at acceptance.
module tb_aes_inv_cipher_iter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] ciphertext;
  logic [127:0] last_key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] plaintext;
  logic         busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  logic [127:0] exp_q [$];

  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_KEY = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_KEY  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

  aes_inv_cipher_iter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ciphertext(ciphertext),
    .last_key  (last_key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .plaintext (plaintext),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] pop_exp();
    if (exp_q.size() == 0) return 'x;
    return exp_q.pop_front();
  endfunction

  // Present a job and hold it until accepted; ok reports whether in_ready came.
  task automatic send(input logic [127:0] ct, input logic [127:0] key,
                      input logic [127:0] expv, output bit ok);
    int n;
    n          = 0;
    ciphertext = ct;
    last_key   = key;
    in_valid   = 1'b1;
    while (!in_ready && n < 40) begin
      step();
      n++;
    end
    ok = in_ready;
    step();
    in_valid = 1'b0;
    if (ok) exp_q.push_back(expv);
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (!out_valid && n < 40) begin
      step();
      n++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    ciphertext = '0; last_key = '0;
    repeat (3) step();
    n_checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: out_valid=%b busy=%b, expected 0 0", out_valid, busy);
    end
    n_checks++;
    if (plaintext !== 128'h0) begin
      n_fail++;
      $display("FAIL reset_plaintext: got %h, expected 0", plaintext);
    end
    rst_n = 1'b1;
    step();
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b, expected 1", in_ready);
    end
  endtask

  task automatic test_fips_c1();
    bit ok; int lat; logic [127:0] e;
    send(C1_CT, C1_KEY, C1_PT, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL c1_accept: in_ready=%b, expected 1", in_ready); end
    wait_out(lat);
    n_checks++;
    if (lat != 10) begin n_fail++; $display("FAIL c1_latency: got %0d cycles, expected 10", lat); end
    e = pop_exp();
    n_checks++;
    if (plaintext !== e) begin n_fail++; $display("FAIL c1_plaintext: got %h, expected %h", plaintext, e); end
    n_checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL c1_done_flags: busy=%b in_ready=%b, expected 1 0", busy, in_ready);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || plaintext !== C1_PT) begin
      n_fail++;
      $display("FAIL c1_release: out_valid=%b in_ready=%b busy=%b pt=%h, expected 0 1 0 %h",
               out_valid, in_ready, busy, plaintext, C1_PT);
    end
  endtask

  task automatic test_app_b();
    bit ok; int lat; logic [127:0] e;
    send(B_CT, B_KEY, B_PT, ok);
    wait_out(lat);
    e = pop_exp();
    n_checks++;
    if (!ok || lat != 10 || plaintext !== e) begin
      n_fail++;
      $display("FAIL appb_plaintext: got %h after %0d cycles, expected %h after 10", plaintext, lat, e);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    bit ok; int lat; int bad; logic [127:0] e;
    send(C1_CT, C1_KEY, C1_PT, ok);
    wait_out(lat);
    e = pop_exp();
    n_checks++;
    if (plaintext !== e) begin n_fail++; $display("FAIL bp_plaintext: got %h, expected %h", plaintext, e); end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (out_valid !== 1'b1 || plaintext !== e || in_ready !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL bp_hold: %0d unstable cycles, expected 0", bad); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_release: in_ready=%b out_valid=%b, expected 1 0", in_ready, out_valid);
    end
    send(B_CT, B_KEY, B_PT, ok);
    wait_out(lat);
    e = pop_exp();
    n_checks++;
    if (!ok || plaintext !== e) begin n_fail++; $display("FAIL bp_second: got %h, expected %h", plaintext, e); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit ok; int lat; logic [127:0] e;
    send(C1_CT, C1_KEY, C1_PT, ok);
    repeat (5) step();
    rst_n = 1'b0;
    step();
    n_checks++;
    if (out_valid !== 1'b0 || plaintext !== 128'h0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_state: out_valid=%b pt=%h busy=%b in_ready=%b, expected 0 0 0 1",
               out_valid, plaintext, busy, in_ready);
    end
    rst_n = 1'b1;
    exp_q.delete();
    send(B_CT, B_KEY, B_PT, ok);
    wait_out(lat);
    e = pop_exp();
    n_checks++;
    if (!ok || lat != 10 || plaintext !== e) begin
      n_fail++;
      $display("FAIL midrst_fresh: got %h after %0d cycles, expected %h after 10", plaintext, lat, e);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_busy_ignore();
    bit ok; int lat; int bad; logic [127:0] e;
    send(C1_CT, C1_KEY, C1_PT, ok);
    repeat (2) step();
    ciphertext = B_CT;
    last_key   = B_KEY;
    in_valid   = 1'b1;
    repeat (3) step();
    in_valid   = 1'b0;
    wait_out(lat);
    e = pop_exp();
    n_checks++;
    if (lat != 5 || plaintext !== e) begin
      n_fail++;
      $display("FAIL busy_result: got %h after %0d more cycles, expected %h after 5", plaintext, lat, e);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    bad = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (busy !== 1'b0 || out_valid !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL busy_no_second: %0d busy cycles, expected 0", bad); end
  endtask

  task automatic test_back_to_back();
    int t0, t1, seen, n; bit acc1, acc2; logic [127:0] e;
    t0 = 0; t1 = 0; seen = 0; n = 0; acc1 = 0; acc2 = 0;
    out_ready  = 1'b1;
    ciphertext = C1_CT;
    last_key   = C1_KEY;
    in_valid   = 1'b1;
    while (seen < 2 && n < 80) begin
      bit fire;
      fire = in_valid && in_ready;
      step();
      n++;
      if (fire) begin
        if (!acc1) begin
          acc1 = 1; t0 = cyc; exp_q.push_back(C1_PT);
          ciphertext = B_CT; last_key = B_KEY;
        end else begin
          acc2 = 1; t1 = cyc; exp_q.push_back(B_PT);
          in_valid = 1'b0;
        end
      end
      if (out_valid) begin
        e = pop_exp();
        seen++;
        n_checks++;
        if (plaintext !== e) begin n_fail++; $display("FAIL b2b_result%0d: got %h, expected %h", seen, plaintext, e); end
      end
    end
    in_valid = 1'b0;
    n_checks++;
    if (seen != 2) begin n_fail++; $display("FAIL b2b_count: %0d results, expected 2", seen); end
    n_checks++;
    if (!(acc1 && acc2) || (t1 - t0) != 12) begin
      n_fail++;
      $display("FAIL b2b_interval: %0d cycles between acceptances, expected 12", t1 - t0);
    end
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fips_c1();
    test_app_b();
    test_backpressure();
    test_reset_mid();
    test_busy_ignore();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule
